// File: rtl/l44_pkg.sv
// Shared constants for the 16-bit registered priority encoder.
package l44_pkg;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 4;
    localparam int BYTE_W = 8;
    localparam int BIDX_W = 3;

    localparam logic [OUT_W-1:0] Y_RST     = '0;
    localparam logic             VALID_RST = 1'b0;

endpackage

// File: rtl/l44_pe8.sv
// Combinational 8-to-3 priority encoder; bit 7 wins, valid flags any set bit.
module l44_pe8
    import l44_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    output logic [BIDX_W-1:0] o_idx,
    output logic              o_valid
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            if (i_a[i]) begin
                o_idx = BIDX_W'(i);
            end
        end
    end

    assign o_valid = |i_a;

endmodule

// File: rtl/l44_prio_enc.sv
// Registered 16-bit priority encoder built from two byte-wide encoders.
module l44_prio_enc
    import l44_pkg::*;
#(
    parameter int IN_W  = l44_pkg::IN_W,
    parameter int OUT_W = l44_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  a,
    output logic [OUT_W-1:0] y,
    output logic             valid
);

    logic [BIDX_W-1:0] w_hi_idx;
    logic [BIDX_W-1:0] w_lo_idx;
    logic              w_hi_valid;
    logic              w_lo_valid;
    logic [OUT_W-1:0]  w_idx;
    logic              w_any;
    logic [OUT_W-1:0]  r_y;
    logic              r_valid;

    l44_pe8 u_pe8_hi (
        .i_a     (a[IN_W-1:BYTE_W]),
        .o_idx   (w_hi_idx),
        .o_valid (w_hi_valid)
    );

    l44_pe8 u_pe8_lo (
        .i_a     (a[BYTE_W-1:0]),
        .o_idx   (w_lo_idx),
        .o_valid (w_lo_valid)
    );

    // Upper byte dominates; its index gets the MSB set.
    assign w_idx = w_hi_valid ? {1'b1, w_hi_idx} : {1'b0, w_lo_idx};
    assign w_any = w_hi_valid | w_lo_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= Y_RST;
            r_valid <= VALID_RST;
        end else if (en) begin
            r_y     <= w_idx;
            r_valid <= w_any;
        end
    end

    assign y     = r_y;
    assign valid = r_valid;

endmodule

// File: tb/tb_l44_prio_enc.sv
// Directed and exhaustive checks of the registered 16-bit priority encoder.
module tb_l44_prio_enc;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] a;
    logic [3:0]  y;
    logic        valid;

    int checks = 0;
    int errors = 0;

    l44_prio_enc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_idx(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic drive_cycle(input logic [15:0] av, input logic ev);
        @(negedge clk);
        a  = av;
        en = ev;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (y !== 4'd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: got y=%0d valid=%b, want y=0 valid=0", y, valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(16'hFFFF, 1'b1);
        checks++;
        if (y !== 4'd15 || valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_precapture: got y=%0d valid=%b, want y=15 valid=1", y, valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 4'd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got y=%0d valid=%b, want y=0 valid=0", y, valid);
        end
        a  = 16'h8000;
        en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y !== 4'd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got y=%0d valid=%b, want y=0 valid=0", y, valid);
        end
        @(negedge clk);
        a     = 16'h0000;
        en    = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y !== 4'd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got y=%0d valid=%b, want y=0 valid=0", y, valid);
        end
        drive_cycle(16'h0010, 1'b1);
        checks++;
        if (y !== 4'd4 || valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_capture: got y=%0d valid=%b, want y=4 valid=1", y, valid);
        end
    endtask

    task automatic test_one_hot();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 16'h0001 << i;
            drive_cycle(v, 1'b1);
            checks++;
            if (y !== 4'(i) || valid !== 1'b1) begin
                errors++;
                $display("FAIL one_hot_%0d: got y=%0d valid=%b, want y=%0d valid=1", i, y, valid, i);
            end
        end
    endtask

    task automatic test_priority();
        logic [15:0] vecs [4] = '{16'hFFFF, 16'h0300, 16'h8001, 16'h0006};
        logic [3:0]  exps [4] = '{4'd15, 4'd9, 4'd15, 4'd2};
        for (int k = 0; k < 4; k++) begin
            drive_cycle(vecs[k], 1'b1);
            checks++;
            if (y !== exps[k] || valid !== 1'b1) begin
                errors++;
                $display("FAIL priority_%h: got y=%0d valid=%b, want y=%0d valid=1", vecs[k], y, valid, exps[k]);
            end
        end
    endtask

    task automatic test_zero_vs_bit0();
        drive_cycle(16'h0000, 1'b1);
        checks++;
        if (y !== 4'd0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_input: got y=%0d valid=%b, want y=0 valid=0", y, valid);
        end
        drive_cycle(16'h0001, 1'b1);
        checks++;
        if (y !== 4'd0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL bit0_input: got y=%0d valid=%b, want y=0 valid=1", y, valid);
        end
    endtask

    task automatic test_enable_hold();
        drive_cycle(16'h0400, 1'b1);
        checks++;
        if (y !== 4'd10 || valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_capture: got y=%0d valid=%b, want y=10 valid=1", y, valid);
        end
        for (int c = 0; c < 3; c++) begin
            drive_cycle(16'h0001, 1'b0);
            checks++;
            if (y !== 4'd10 || valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle_%0d: got y=%0d valid=%b, want y=10 valid=1", c, y, valid);
            end
        end
        drive_cycle(16'h0001, 1'b1);
        checks++;
        if (y !== 4'd0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got y=%0d valid=%b, want y=0 valid=1", y, valid);
        end
        drive_cycle(16'h0000, 1'b0);
        checks++;
        if (y !== 4'd0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_zero_ignored: got y=%0d valid=%b, want y=0 valid=1", y, valid);
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] v;
        logic [3:0]  ey;
        logic        ev;
        for (int n = 0; n < 65536; n++) begin
            v  = 16'(n);
            ey = ref_idx(v);
            ev = |v;
            drive_cycle(v, 1'b1);
            checks++;
            if (y !== ey || valid !== ev) begin
                errors++;
                $display("FAIL exhaustive_%h: got y=%0d valid=%b, want y=%0d valid=%b", v, y, valid, ey, ev);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        a     = 16'h0000;
        #2;
        test_reset();
        test_one_hot();
        test_priority();
        test_zero_vs_bit0();
        test_enable_hold();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
